// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the clock-gate sequencing controller:
// the sequencer state encoding and the phase-counter width function.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } gate_state_t;

    // Wide enough to hold the largest phase length without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with an asynchronous
// reset and a parameterized reset value.
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Wake/drain sequencer driving the CE pin of a gated global clock buffer.
// Optional idle auto-off is enabled by defining CLK_GATE_AUTO_OFF_EN.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int WAKE_CYCLES   = 4,
    parameter int MIN_ON_CYCLES = 8,
    parameter int DRAIN_CYCLES  = 16,
    parameter int IDLE_CYCLES   = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic activity,
    output logic ce,
    output logic ack,
    output logic busy
);

    localparam int CNT_W = cnt_width(WAKE_CYCLES, MIN_ON_CYCLES, DRAIN_CYCLES, IDLE_CYCLES);

    localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LOAD   = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    gate_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ce_reg, ack_reg, busy_reg;
    logic             req_s;
    logic             disarm_reg;
    logic             idle_expired;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (req),
        .q     (req_s)
    );

`ifdef CLK_GATE_AUTO_OFF_EN
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

    logic [CNT_W-1:0] idle_reg, idle_next;
    logic             disarm_next;

    // Idle timer is armed on every entry to ON and restarted by activity.
    always_comb begin
        idle_next = idle_reg;
        if (state_reg != ON) begin
            if (state_next == ON)
                idle_next = IDLE_LOAD;
        end else if (activity) begin
            idle_next = IDLE_LOAD;
        end else if (idle_reg != '0) begin
            idle_next = idle_reg - 1'b1;
        end
    end

    // Leaving ON while req_s is still high can only be the idle timeout.
    always_comb begin
        disarm_next = disarm_reg;
        if (!req_s)
            disarm_next = 1'b0;
        else if (state_reg == ON && state_next == DRAIN)
            disarm_next = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_reg   <= '0;
            disarm_reg <= 1'b0;
        end else begin
            idle_reg   <= idle_next;
            disarm_reg <= disarm_next;
        end
    end

    assign idle_expired = (idle_reg == '0);
`else
    logic unused_activity;
    assign unused_activity = activity;
    assign disarm_reg      = 1'b0;
    assign idle_expired    = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            OFF: begin
                if (req_s && !disarm_reg) begin
                    state_next = WAKE;
                    cnt_next   = WAKE_LOAD;
                end
            end
            WAKE: begin
                if (cnt_reg == '0) begin
                    state_next = ON;
                    cnt_next   = MIN_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ON: begin
                if (cnt_reg == '0 && (!req_s || idle_expired)) begin
                    state_next = DRAIN;
                    cnt_next   = DRAIN_LOAD;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DRAIN: begin
                // Min-on was already met before draining, so return with it satisfied.
                if (req_s && !disarm_reg) begin
                    state_next = ON;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    state_next = OFF;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = OFF;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so CE never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= OFF;
            cnt_reg   <= '0;
            ce_reg    <= 1'b0;
            ack_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ce_reg    <= (state_next != OFF);
            ack_reg   <= (state_next == ON);
            busy_reg  <= (state_next == WAKE) || (state_next == DRAIN);
        end
    end

    assign ce   = ce_reg;
    assign ack  = ack_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: expected {ce,ack,busy} per cycle is
// queued from the sequencing timeline and compared one cycle at a time.
module tb_clk_gate_ctrl;

    localparam logic [2:0] S_OFF   = 3'b000;
    localparam logic [2:0] S_WAKE  = 3'b101;
    localparam logic [2:0] S_ON    = 3'b110;
    localparam logic [2:0] S_DRAIN = 3'b101;

    logic clk;
    logic reset;
    logic req;
    logic activity;
    logic ce;
    logic ack;
    logic busy;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];

    clk_gate_ctrl #(
        .WAKE_CYCLES   (4),
        .MIN_ON_CYCLES (8),
        .DRAIN_CYCLES  (16),
        .IDLE_CYCLES   (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .activity (activity),
        .ce       (ce),
        .ack      (ack),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_exp(input logic [2:0] v, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [2:0] obs, exp_v;
        reset = 1'b1; req = 1'b0; activity = 1'b0;
        push_exp(S_OFF, 6);
        for (int i = 1; i <= 6; i++) begin
            if (i == 4) reset = 1'b0;
            @(negedge clk);
            obs = {ce, ack, busy};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL reset cyc=%0d ce/ack/busy got=%b expected=%b", i, obs, exp_v);
            end
            $display("reset cyc=%0d ce/ack/busy=%b", i, obs);
        end
    endtask

    // Full wake, extended ON, release, full drain to OFF.
    task automatic test_wake_and_drain();
        logic [2:0] obs, exp_v;
        push_exp(S_OFF, 2); push_exp(S_WAKE, 4); push_exp(S_ON, 14);
        push_exp(S_DRAIN, 16); push_exp(S_OFF, 4);
        for (int i = 1; i <= 40; i++) begin
            req = (i < 19);
            @(negedge clk);
            obs = {ce, ack, busy};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL wake_drain cyc=%0d ce/ack/busy got=%b expected=%b", i, obs, exp_v);
            end
            $display("wake_drain cyc=%0d req=%b ce/ack/busy=%b", i, req, obs);
        end
    endtask

    // Two-cycle request: wake completes, min-on holds 8 cycles, then drain.
    task automatic test_short_req();
        logic [2:0] obs, exp_v;
        push_exp(S_OFF, 2); push_exp(S_WAKE, 4); push_exp(S_ON, 8);
        push_exp(S_DRAIN, 16); push_exp(S_OFF, 3);
        for (int i = 1; i <= 33; i++) begin
            req = (i < 3);
            @(negedge clk);
            obs = {ce, ack, busy};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL short_req cyc=%0d ce/ack/busy got=%b expected=%b", i, obs, exp_v);
            end
            $display("short_req cyc=%0d req=%b ce/ack/busy=%b", i, req, obs);
        end
    endtask

    // Re-request at drain cycle 5, then an early release proving min-on is not reloaded.
    task automatic test_drain_reenter();
        logic [2:0] obs, exp_v;
        logic       ce_fell;
        ce_fell = 1'b0;
        push_exp(S_OFF, 2); push_exp(S_WAKE, 4); push_exp(S_ON, 11);
        push_exp(S_DRAIN, 6); push_exp(S_ON, 4); push_exp(S_DRAIN, 16); push_exp(S_OFF, 3);
        for (int i = 1; i <= 46; i++) begin
            req = (i < 16) || (i >= 22 && i < 26);
            @(negedge clk);
            obs = {ce, ack, busy};
            if (i >= 3 && i <= 43 && ce !== 1'b1) ce_fell = 1'b1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL drain_reenter cyc=%0d ce/ack/busy got=%b expected=%b", i, obs, exp_v);
            end
            $display("drain_reenter cyc=%0d req=%b ce/ack/busy=%b", i, req, obs);
        end
        checks++;
        if (ce_fell !== 1'b0) begin
            failures++;
            $display("FAIL drain_reenter_ce_held ce_fell got=%b expected=0", ce_fell);
        end
    endtask

    // Asynchronous reset in WAKE cycle 2, released with req held high.
    task automatic test_reset_mid_wake();
        logic [2:0] obs, exp_v;
        push_exp(S_OFF, 2); push_exp(S_WAKE, 2);
        for (int i = 1; i <= 4; i++) begin
            req = 1'b1;
            @(negedge clk);
            obs = {ce, ack, busy};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL mid_wake_pre cyc=%0d ce/ack/busy got=%b expected=%b", i, obs, exp_v);
            end
            $display("mid_wake_pre cyc=%0d ce/ack/busy=%b", i, obs);
        end
        #2 reset = 1'b1;
        #1;
        obs = {ce, ack, busy};
        checks++;
        if (obs !== S_OFF) begin
            failures++;
            $display("FAIL async_reset ce/ack/busy got=%b expected=%b", obs, S_OFF);
        end
        $display("async_reset ce/ack/busy=%b", obs);
        @(negedge clk);
        reset = 1'b0;
        push_exp(S_OFF, 2); push_exp(S_WAKE, 4); push_exp(S_ON, 3);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            obs = {ce, ack, busy};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL mid_wake_restart cyc=%0d ce/ack/busy got=%b expected=%b", i, obs, exp_v);
            end
            $display("mid_wake_restart cyc=%0d ce/ack/busy=%b", i, obs);
        end
    endtask

`ifdef CLK_GATE_AUTO_OFF_EN
    // Idle timeout drains with req high, stays OFF until req is seen low then high.
    task automatic test_auto_off();
        logic [2:0] obs, exp_v;
        activity = 1'b0;
        push_exp(S_OFF, 2); push_exp(S_WAKE, 4); push_exp(S_ON, 64);
        push_exp(S_DRAIN, 16); push_exp(S_OFF, 10);
        for (int i = 1; i <= 96; i++) begin
            req = 1'b1;
            @(negedge clk);
            obs = {ce, ack, busy};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL auto_off cyc=%0d ce/ack/busy got=%b expected=%b", i, obs, exp_v);
            end
            $display("auto_off cyc=%0d ce/ack/busy=%b", i, obs);
        end
        push_exp(S_OFF, 5); push_exp(S_WAKE, 4); push_exp(S_ON, 2);
        for (int i = 1; i <= 11; i++) begin
            req = (i >= 4);
            @(negedge clk);
            obs = {ce, ack, busy};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL auto_off_rearm cyc=%0d ce/ack/busy got=%b expected=%b", i, obs, exp_v);
            end
            $display("auto_off_rearm cyc=%0d req=%b ce/ack/busy=%b", i, req, obs);
        end
    endtask
`else
    // Without auto-off, an idle but requested domain stays ON.
    task automatic test_no_auto_off();
        logic [2:0] obs, exp_v;
        activity = 1'b0;
        push_exp(S_OFF, 2); push_exp(S_WAKE, 4); push_exp(S_ON, 100);
        for (int i = 1; i <= 106; i++) begin
            req = 1'b1;
            @(negedge clk);
            obs = {ce, ack, busy};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL no_auto_off cyc=%0d ce/ack/busy got=%b expected=%b", i, obs, exp_v);
            end
            $display("no_auto_off cyc=%0d ce/ack/busy=%b", i, obs);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; req = 1'b0; activity = 1'b0;
        test_reset();
        test_wake_and_drain();
        test_short_req();
        test_drain_reenter();
        test_reset_mid_wake();
        do_reset();
`ifdef CLK_GATE_AUTO_OFF_EN
        test_auto_off();
`else
        test_no_auto_off();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout sim_time got=%0t expected=finish before bound", $time);
        $fatal(1, "timeout");
    end

endmodule
